branch_resolve_buffer: RTL and testbench
========================================

Name: branch_resolve_buffer

Overview:
- Sits directly downstream of the BCU, on the ROB side.
- Holds one entry per ROB index for every in-flight branch: predicted direction, branch PC, and, once the BCU reports, the actual direction and next PC.
- At commit it decides whether the prediction was correct. On a mispredict it raises a one-cycle flush with the redirect PC.
- On every committed branch it emits a predictor-update record and keeps commit/mispredict statistics.

Parameters:
- ROB_IDX_W, 4, width of a ROB index; index 0 means "invalid/none".
- ROB_SIZE, 16, number of entries (2**ROB_IDX_W); entry 0 is never used.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- flush_input  input  1  external pipeline flush from ROB; clears all entries
- alloc_valid  input  1  decoder issues a branch this cycle
- alloc_rob_id  input  ROB_IDX_W  ROB index of the issued branch
- alloc_pred_taken  input  1  predicted direction
- alloc_pc  input  32  PC of the branch instruction
- bcu_rob_id  input  ROB_IDX_W  BCU result index; 0 = no result
- bcu_taken  input  1  actual direction
- bcu_value  input  32  actual next PC (target or fallthrough)
- commit_valid  input  1  ROB commits the branch at commit_rob_id
- commit_rob_id  input  ROB_IDX_W  ROB head index
- commit_ready  output  1  combinational: entry at commit_rob_id is valid and resolved
- flush_out  output  1  registered mispredict flush pulse
- redirect_pc  output  32  registered PC to fetch from when flush_out=1
- upd_valid  output  1  registered predictor-update strobe
- upd_pc  output  32  branch PC for the predictor update
- upd_taken  output  1  actual direction for the predictor update
- commit_cnt  output  CNT_W  committed branches
- mispredict_cnt  output  CNT_W  committed mispredicts

Behaviour:
- Per-entry state: valid, resolved, pred_taken, pc, taken, target.
- FSM with two states: IDLE and FLUSH.
- Reset (rst_in=0, asynchronous):
  - all entry bits cleared; state IDLE;
  - flush_out, redirect_pc, upd_valid, upd_pc, upd_taken, commit_cnt and mispredict_cnt all 0.
- Allocate (IDLE, alloc_valid=1, alloc_rob_id!=0): at the edge, the entry is written with valid=1, resolved=0, pred_taken and pc; taken/target are cleared. alloc_rob_id=0 is ignored. Allocating to a valid entry overwrites it.
- Resolve (IDLE, bcu_rob_id!=0): if the entry was valid at cycle start, it gets resolved=1, taken=bcu_taken, target=bcu_value. A result for an invalid entry is dropped silently.
- Allocate and resolve to the same index in the same cycle: the allocate wins and the result is dropped.
- commit_ready = valid[commit_rob_id] & resolved[commit_rob_id], purely combinational. It is 0 for index 0. A result arriving this cycle is not visible until the next cycle.
- Commit (IDLE, commit_valid & commit_ready), with all outputs appearing the cycle after the edge:
  - the entry's valid is cleared;
  - upd_valid=1, upd_pc=pc, upd_taken=taken;
  - commit_cnt increments.
  - If taken != pred_taken: flush_out=1, redirect_pc=target, mispredict_cnt increments, and the FSM moves to FLUSH.
- commit_valid with commit_ready=0 is a protocol violation and is ignored: no state change, no outputs.
- upd_valid and flush_out are single-cycle pulses; they return to 0 unless another commit occurs.
- redirect_pc, upd_pc and upd_taken hold their last values when not strobed.
- FLUSH lasts exactly one cycle, the cycle in which flush_out=1:
  - alloc, bcu and commit inputs are ignored;
  - at the end of the cycle all valid/resolved bits clear and the FSM returns to IDLE;
  - counters are preserved.
- flush_input=1 (any state, synchronous): clears all entries, forces IDLE, drives flush_out and upd_valid to 0 next cycle, and overrides any same-cycle allocate, resolve or commit. Counters are preserved.
- Counters wrap modulo 2**CNT_W.
- Reset asserted mid-FLUSH: outputs go to reset values immediately (asynchronous reset).

Test Plan:
- Correct prediction: alloc id 3, pred 1, pc 0x100; bcu id 3, taken 1, value 0x140; commit id 3 -> commit_ready=1 the cycle after bcu. Next cycle: upd_valid=1, upd_pc=0x100, upd_taken=1, flush_out=0, commit_cnt=1.
- Mispredict: alloc id 5, pred 1, pc 0x200; bcu id 5, taken 0, value 0x204; commit -> next cycle flush_out=1, redirect_pc=0x204, mispredict_cnt=1. The following cycle all commit_ready=0 and flush_out=0.
- Unresolved commit: alloc id 2, then commit id 2 before any bcu result -> commit_ready=0, no upd_valid, counters unchanged, entry still valid. A later bcu id 2 followed by commit then succeeds.
- Ignored results: bcu id 7 with entry 7 invalid, and bcu id 0 -> no entry becomes resolved; commit id 7 gives commit_ready=0. Same-cycle alloc id 4 plus bcu id 4 -> entry 4 valid, unresolved.
- Flush interactions: alloc id 1 in the FLUSH cycle -> dropped. flush_input together with a commit of a resolved mispredict -> no flush_out, no upd_valid, counters unchanged, all entries cleared.
- Reset: pull rst_in low asynchronously while flush_out=1 -> flush_out and both counters read 0 before the next clock edge.

Source files
------------

// File: rtl/branch_resolve_buffer.sv
// Branch resolve buffer: tracks in-flight branches by ROB index, records BCU
// results, checks the prediction at commit and raises a one-cycle mispredict
// flush with the redirect PC. Also emits predictor updates and statistics.
module branch_resolve_buffer #(
    parameter int ROB_IDX_W = 4,
    parameter int ROB_SIZE  = 16,
    parameter int CNT_W     = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 flush_input,
    input  logic                 alloc_valid,
    input  logic [ROB_IDX_W-1:0] alloc_rob_id,
    input  logic                 alloc_pred_taken,
    input  logic [31:0]          alloc_pc,
    input  logic [ROB_IDX_W-1:0] bcu_rob_id,
    input  logic                 bcu_taken,
    input  logic [31:0]          bcu_value,
    input  logic                 commit_valid,
    input  logic [ROB_IDX_W-1:0] commit_rob_id,
    output logic                 commit_ready,
    output logic                 flush_out,
    output logic [31:0]          redirect_pc,
    output logic                 upd_valid,
    output logic [31:0]          upd_pc,
    output logic                 upd_taken,
    output logic [CNT_W-1:0]     commit_cnt,
    output logic [CNT_W-1:0]     mispredict_cnt
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t              state_q;
    logic [ROB_SIZE-1:0] valid_q;
    logic [ROB_SIZE-1:0] resolved_q;
    logic [ROB_SIZE-1:0] pred_q;
    logic [ROB_SIZE-1:0] taken_q;
    logic [31:0]         pc_q     [ROB_SIZE];
    logic [31:0]         target_q [ROB_SIZE];

    logic alloc_go;
    logic resolve_go;
    logic commit_go;
    logic mispredict;

    // Head-of-ROB readiness and decode of this cycle's alloc/resolve/commit actions
    always_comb begin
        commit_ready = (commit_rob_id != '0) & valid_q[commit_rob_id] & resolved_q[commit_rob_id];
        alloc_go     = alloc_valid & (alloc_rob_id != '0);
        // A result racing an allocate to the same slot belongs to the old branch: drop it
        resolve_go   = (bcu_rob_id != '0) & valid_q[bcu_rob_id] &
                       ~(alloc_go & (alloc_rob_id == bcu_rob_id));
        commit_go    = commit_valid & commit_ready;
        mispredict   = taken_q[commit_rob_id] != pred_q[commit_rob_id];
    end

    // Control FSM, entry table and registered outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= IDLE;
            valid_q        <= '0;
            resolved_q     <= '0;
            pred_q         <= '0;
            taken_q        <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                pc_q[i]     <= '0;
                target_q[i] <= '0;
            end
            flush_out      <= 1'b0;
            redirect_pc    <= '0;
            upd_valid      <= 1'b0;
            upd_pc         <= '0;
            upd_taken      <= 1'b0;
            commit_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (flush_input || state_q == FLUSH) begin
            // External flush or the end of our own flush cycle: drop every in-flight branch
            state_q    <= IDLE;
            valid_q    <= '0;
            resolved_q <= '0;
            flush_out  <= 1'b0;
            upd_valid  <= 1'b0;
        end else begin
            flush_out <= 1'b0;
            upd_valid <= 1'b0;

            if (commit_go) begin
                valid_q[commit_rob_id] <= 1'b0;
                upd_valid              <= 1'b1;
                upd_pc                 <= pc_q[commit_rob_id];
                upd_taken              <= taken_q[commit_rob_id];
                commit_cnt             <= commit_cnt + 1'b1;
                if (mispredict) begin
                    flush_out      <= 1'b1;
                    redirect_pc    <= target_q[commit_rob_id];
                    mispredict_cnt <= mispredict_cnt + 1'b1;
                    state_q        <= FLUSH;
                end
            end

            if (resolve_go) begin
                resolved_q[bcu_rob_id] <= 1'b1;
                taken_q[bcu_rob_id]    <= bcu_taken;
                target_q[bcu_rob_id]   <= bcu_value;
            end

            // Allocation last so it overrides a same-slot commit clear
            if (alloc_go) begin
                valid_q[alloc_rob_id]    <= 1'b1;
                resolved_q[alloc_rob_id] <= 1'b0;
                pred_q[alloc_rob_id]     <= alloc_pred_taken;
                pc_q[alloc_rob_id]       <= alloc_pc;
                taken_q[alloc_rob_id]    <= 1'b0;
                target_q[alloc_rob_id]   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_buffer.sv
// Directed bench for branch_resolve_buffer.
module tb_branch_resolve_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        flush_input;
    logic        alloc_valid;
    logic [3:0]  alloc_rob_id;
    logic        alloc_pred_taken;
    logic [31:0] alloc_pc;
    logic [3:0]  bcu_rob_id;
    logic        bcu_taken;
    logic [31:0] bcu_value;
    logic        commit_valid;
    logic [3:0]  commit_rob_id;
    logic        commit_ready;
    logic        flush_out;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] commit_cnt;
    logic [31:0] mispredict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve_buffer #(.ROB_IDX_W(4), .ROB_SIZE(16), .CNT_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_input(flush_input),
        .alloc_valid(alloc_valid), .alloc_rob_id(alloc_rob_id),
        .alloc_pred_taken(alloc_pred_taken), .alloc_pc(alloc_pc),
        .bcu_rob_id(bcu_rob_id), .bcu_taken(bcu_taken), .bcu_value(bcu_value),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
        .commit_ready(commit_ready), .flush_out(flush_out), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .commit_cnt(commit_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        flush_input = 0; alloc_valid = 0; alloc_rob_id = 0; alloc_pred_taken = 0; alloc_pc = 0;
        bcu_rob_id = 0; bcu_taken = 0; bcu_value = 0; commit_valid = 0; commit_rob_id = 0;
    endtask

    task automatic do_alloc(input logic [3:0] id, input logic pred, input logic [31:0] pc);
        alloc_valid = 1; alloc_rob_id = id; alloc_pred_taken = pred; alloc_pc = pc;
        tick();
        alloc_valid = 0; alloc_rob_id = 0;
    endtask

    task automatic do_bcu(input logic [3:0] id, input logic tk, input logic [31:0] val);
        bcu_rob_id = id; bcu_taken = tk; bcu_value = val;
        tick();
        bcu_rob_id = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 0;
        #12;
        n_checks++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL reset_flush_out got=%0b exp=0", flush_out); end
        n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid got=%0b exp=0", upd_valid); end
        n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
        n_checks++; if (upd_pc !== 32'h0 || upd_taken !== 1'b0) begin n_fail++; $display("FAIL reset_upd got=%h/%0b exp=0/0", upd_pc, upd_taken); end
        n_checks++; if (commit_cnt !== 32'd0 || mispredict_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", commit_cnt, mispredict_cnt); end
        n_checks++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL reset_commit_ready got=%0b exp=0", commit_ready); end
        @(negedge clk_in);
        rst_in = 1;
        tick();
    endtask

    task automatic test_correct_predict();
        do_alloc(4'd3, 1'b1, 32'h100);
        bcu_rob_id = 3; bcu_taken = 1; bcu_value = 32'h140; commit_rob_id = 3;
        #1;
        n_checks++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL cp_ready_same_cycle got=%0b exp=0", commit_ready); end
        tick();
        bcu_rob_id = 0;
        n_checks++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL cp_ready_after_bcu got=%0b exp=1", commit_ready); end
        commit_valid = 1;
        tick();
        commit_valid = 0;
        n_checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h100 || upd_taken !== 1'b1) begin n_fail++; $display("FAIL cp_update got=%0b/%h/%0b exp=1/00000100/1", upd_valid, upd_pc, upd_taken); end
        n_checks++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL cp_flush_out got=%0b exp=0", flush_out); end
        n_checks++; if (commit_cnt !== 32'd1 || mispredict_cnt !== 32'd0) begin n_fail++; $display("FAIL cp_counters got=%0d/%0d exp=1/0", commit_cnt, mispredict_cnt); end
        n_checks++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL cp_entry_freed got=%0b exp=0", commit_ready); end
        tick();
        n_checks++; if (upd_valid !== 1'b0 || upd_pc !== 32'h100) begin n_fail++; $display("FAIL cp_upd_pulse got=%0b/%h exp=0/00000100", upd_valid, upd_pc); end
        commit_rob_id = 0;
    endtask

    task automatic test_mispredict();
        do_alloc(4'd5, 1'b1, 32'h200);
        do_alloc(4'd6, 1'b0, 32'h280);
        do_bcu(4'd6, 1'b0, 32'h284);
        do_bcu(4'd5, 1'b0, 32'h204);
        commit_rob_id = 6; #1;
        n_checks++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL mp_ready6_before got=%0b exp=1", commit_ready); end
        commit_rob_id = 5; #1;
        n_checks++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL mp_ready5 got=%0b exp=1", commit_ready); end
        commit_valid = 1;
        tick();
        commit_valid = 0;
        n_checks++; if (flush_out !== 1'b1 || redirect_pc !== 32'h204) begin n_fail++; $display("FAIL mp_flush got=%0b/%h exp=1/00000204", flush_out, redirect_pc); end
        n_checks++; if (commit_cnt !== 32'd2 || mispredict_cnt !== 32'd1) begin n_fail++; $display("FAIL mp_counters got=%0d/%0d exp=2/1", commit_cnt, mispredict_cnt); end
        n_checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h200 || upd_taken !== 1'b0) begin n_fail++; $display("FAIL mp_update got=%0b/%h/%0b exp=1/00000200/0", upd_valid, upd_pc, upd_taken); end
        // Allocation during the flush cycle must be dropped
        alloc_valid = 1; alloc_rob_id = 1; alloc_pred_taken = 1; alloc_pc = 32'h600;
        tick();
        alloc_valid = 0; alloc_rob_id = 0;
        n_checks++; if (flush_out !== 1'b0 || upd_valid !== 1'b0) begin n_fail++; $display("FAIL mp_pulse_end got=%0b/%0b exp=0/0", flush_out, upd_valid); end
        commit_rob_id = 6; #1;
        n_checks++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL mp_entry6_cleared got=%0b exp=0", commit_ready); end
        do_bcu(4'd1, 1'b1, 32'h640);
        commit_rob_id = 1; #1;
        n_checks++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL mp_alloc_in_flush_dropped got=%0b exp=0", commit_ready); end
        n_checks++; if (redirect_pc !== 32'h204 || commit_cnt !== 32'd2 || mispredict_cnt !== 32'd1) begin n_fail++; $display("FAIL mp_hold got=%h/%0d/%0d exp=00000204/2/1", redirect_pc, commit_cnt, mispredict_cnt); end
        commit_rob_id = 0;
    endtask

    task automatic test_unresolved_commit();
        do_alloc(4'd2, 1'b0, 32'h300);
        commit_rob_id = 2; commit_valid = 1; #1;
        n_checks++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL ur_ready got=%0b exp=0", commit_ready); end
        tick();
        commit_valid = 0;
        n_checks++; if (upd_valid !== 1'b0 || flush_out !== 1'b0) begin n_fail++; $display("FAIL ur_no_outputs got=%0b/%0b exp=0/0", upd_valid, flush_out); end
        n_checks++; if (commit_cnt !== 32'd2 || mispredict_cnt !== 32'd1) begin n_fail++; $display("FAIL ur_counters got=%0d/%0d exp=2/1", commit_cnt, mispredict_cnt); end
        do_bcu(4'd2, 1'b0, 32'h304);
        n_checks++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL ur_ready_later got=%0b exp=1", commit_ready); end
        commit_valid = 1;
        tick();
        commit_valid = 0;
        n_checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h300 || upd_taken !== 1'b0 || flush_out !== 1'b0) begin n_fail++; $display("FAIL ur_commit got=%0b/%h/%0b/%0b exp=1/00000300/0/0", upd_valid, upd_pc, upd_taken, flush_out); end
        n_checks++; if (commit_cnt !== 32'd3) begin n_fail++; $display("FAIL ur_commit_cnt got=%0d exp=3", commit_cnt); end
        commit_rob_id = 0;
    endtask

    task automatic test_ignored_results();
        do_bcu(4'd7, 1'b1, 32'h700);
        do_bcu(4'd0, 1'b1, 32'h710);
        commit_rob_id = 7; #1;
        n_checks++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL ig_ready7 got=%0b exp=0", commit_ready); end
        commit_rob_id = 0; #1;
        n_checks++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL ig_ready0 got=%0b exp=0", commit_ready); end
        alloc_valid = 1; alloc_rob_id = 4; alloc_pred_taken = 0; alloc_pc = 32'h480;
        bcu_rob_id = 4; bcu_taken = 1; bcu_value = 32'h4c0;
        tick();
        alloc_valid = 0; alloc_rob_id = 0; bcu_rob_id = 0;
        commit_rob_id = 4; #1;
        n_checks++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL ig_same_cycle got=%0b exp=0", commit_ready); end
        do_bcu(4'd4, 1'b0, 32'h484);
        n_checks++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL ig_entry4_valid got=%0b exp=1", commit_ready); end
        commit_rob_id = 0;
    endtask

    task automatic test_flush_input();
        do_alloc(4'd8, 1'b1, 32'h400);
        do_bcu(4'd8, 1'b0, 32'h408);
        commit_rob_id = 8; #1;
        n_checks++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL fi_ready8 got=%0b exp=1", commit_ready); end
        flush_input = 1; commit_valid = 1;
        tick();
        flush_input = 0; commit_valid = 0;
        n_checks++; if (flush_out !== 1'b0 || upd_valid !== 1'b0) begin n_fail++; $display("FAIL fi_no_pulse got=%0b/%0b exp=0/0", flush_out, upd_valid); end
        n_checks++; if (commit_cnt !== 32'd3 || mispredict_cnt !== 32'd1) begin n_fail++; $display("FAIL fi_counters got=%0d/%0d exp=3/1", commit_cnt, mispredict_cnt); end
        n_checks++; if (upd_pc !== 32'h300 || redirect_pc !== 32'h204) begin n_fail++; $display("FAIL fi_hold got=%h/%h exp=00000300/00000204", upd_pc, redirect_pc); end
        n_checks++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL fi_entry8_cleared got=%0b exp=0", commit_ready); end
        commit_rob_id = 4; #1;
        n_checks++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL fi_entry4_cleared got=%0b exp=0", commit_ready); end
        commit_rob_id = 0;
    endtask

    task automatic test_reset_mid_flush();
        do_alloc(4'd9, 1'b0, 32'h500);
        do_bcu(4'd9, 1'b1, 32'h540);
        commit_rob_id = 9; commit_valid = 1;
        tick();
        commit_valid = 0; commit_rob_id = 0;
        n_checks++; if (flush_out !== 1'b1 || redirect_pc !== 32'h540 || mispredict_cnt !== 32'd2 || commit_cnt !== 32'd4) begin n_fail++; $display("FAIL rm_flush got=%0b/%h/%0d/%0d exp=1/00000540/2/4", flush_out, redirect_pc, mispredict_cnt, commit_cnt); end
        #2 rst_in = 0;
        #1;
        n_checks++; if (flush_out !== 1'b0 || commit_cnt !== 32'd0 || mispredict_cnt !== 32'd0) begin n_fail++; $display("FAIL rm_async got=%0b/%0d/%0d exp=0/0/0", flush_out, commit_cnt, mispredict_cnt); end
        n_checks++; if (redirect_pc !== 32'h0 || upd_valid !== 1'b0) begin n_fail++; $display("FAIL rm_outputs got=%h/%0b exp=00000000/0", redirect_pc, upd_valid); end
        @(negedge clk_in);
        rst_in = 1;
        tick();
        n_checks++; if (flush_out !== 1'b0 || commit_cnt !== 32'd0) begin n_fail++; $display("FAIL rm_after got=%0b/%0d exp=0/0", flush_out, commit_cnt); end
    endtask

    initial begin
        test_reset();
        test_correct_predict();
        test_mispredict();
        test_unresolved_commit();
        test_ignored_results();
        test_flush_input();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
